// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//   Multi-cycle control FSM for the RV32I integer core. It fetches one
//   instruction at a time over a req/ack handshake, holds the word on
//   fetched_inst, steps decode/execute/writeback with one-cycle enables and
//   then advances the PC. Unsupported opcodes park the FSM in TRAP until
//   reset. An external halt is honoured only at the instruction boundary.
//
// Ports
//   clk           : core clock, all state changes on the rising edge
//   reset_n       : asynchronous active-low reset
//   imem_req      : fetch request, held high until acknowledged
//   imem_addr     : fetch address (always the current pc)
//   imem_ack      : memory presents imem_rdata this cycle
//   imem_rdata    : instruction word from memory
//   halt          : stop at the next instruction boundary
//   fetched_inst  : latched instruction for the decode unit
//   decode_en     : one-cycle decode strobe
//   exec_en       : one-cycle execute strobe
//   wb_en         : one-cycle register-file write strobe
//   pc            : address of the current instruction
//   busy          : low only in HALTED and TRAP
//   illegal_inst  : sticky unsupported-instruction flag
//   retired_count : instructions that completed writeback (wraps)
// -----------------------------------------------------------------------------
module core_sequencer #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                halt,
  output logic [31:0]         fetched_inst,
  output logic                decode_en,
  output logic                exec_en,
  output logic                wb_en,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                illegal_inst,
  output logic [31:0]         retired_count
);

  localparam logic [2:0] ST_FETCH     = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_WRITEBACK = 3'd3;
  localparam logic [2:0] ST_HALTED    = 3'd4;
  localparam logic [2:0] ST_TRAP      = 3'd5;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(3'd4);

  // Only OP-IMM without the shift variants is executable by the datapath.
  function automatic logic is_supported(input logic [6:0] opcode,
                                        input logic [2:0] funct3);
    logic ok;
    if (opcode == 7'b0010011) begin
      ok = (funct3 != 3'b001) && (funct3 != 3'b101);
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  logic [2:0]          state_r;
  logic [2:0]          state_next_s;
  logic                fetch_accept_s;
  logic                imem_req_r;
  logic                decode_en_r;
  logic                exec_en_r;
  logic                wb_en_r;
  logic                busy_r;
  logic                illegal_r;
  logic [31:0]         fetched_inst_r;
  logic [PC_WIDTH-1:0] pc_r;
  logic [31:0]         retired_r;

  // An ack only counts while our own request is actually on the bus.
  assign fetch_accept_s = (state_r == ST_FETCH) && imem_req_r && imem_ack;

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (fetch_accept_s) begin
          if (is_supported(imem_rdata[6:0], imem_rdata[14:12])) begin
            state_next_s = ST_DECODE;
          end else begin
            state_next_s = ST_TRAP;
          end
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE:    state_next_s = ST_EXECUTE;
      ST_EXECUTE:   state_next_s = ST_WRITEBACK;
      ST_WRITEBACK: state_next_s = halt ? ST_HALTED : ST_FETCH;
      ST_HALTED:    state_next_s = halt ? ST_HALTED : ST_FETCH;
      ST_TRAP:      state_next_s = ST_TRAP;
      default:      state_next_s = ST_TRAP;
    endcase
  end

  // State and all control outputs are registered from the next state, so
  // they never depend combinationally on inputs. After reset the FSM sits in
  // FETCH with the request low for one cycle, then raises it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_FETCH;
      imem_req_r     <= 1'b0;
      decode_en_r    <= 1'b0;
      exec_en_r      <= 1'b0;
      wb_en_r        <= 1'b0;
      busy_r         <= 1'b1;
      illegal_r      <= 1'b0;
      fetched_inst_r <= 32'd0;
      pc_r           <= RESET_PC;
      retired_r      <= 32'd0;
    end else begin
      state_r     <= state_next_s;
      imem_req_r  <= (state_next_s == ST_FETCH);
      decode_en_r <= (state_next_s == ST_DECODE);
      exec_en_r   <= (state_next_s == ST_EXECUTE);
      wb_en_r     <= (state_next_s == ST_WRITEBACK);
      busy_r      <= (state_next_s != ST_HALTED) && (state_next_s != ST_TRAP);
      illegal_r   <= illegal_r | (state_next_s == ST_TRAP);
      if (fetch_accept_s) begin
        fetched_inst_r <= imem_rdata;
      end else begin
        fetched_inst_r <= fetched_inst_r;
      end
      // Retirement happens at the end of the writeback cycle; pc wraps.
      if (state_r == ST_WRITEBACK) begin
        pc_r      <= pc_r + PC_STEP;
        retired_r <= retired_r + 32'd1;
      end else begin
        pc_r      <= pc_r;
        retired_r <= retired_r;
      end
    end
  end

  assign imem_req      = imem_req_r;
  assign imem_addr     = pc_r;
  assign decode_en     = decode_en_r;
  assign exec_en       = exec_en_r;
  assign wb_en         = wb_en_r;
  assign busy          = busy_r;
  assign illegal_inst  = illegal_r;
  assign fetched_inst  = fetched_inst_r;
  assign pc            = pc_r;
  assign retired_count = retired_r;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] SLTI = 32'h00A02113;
  localparam logic [31:0] SLLI = 32'h00109093;
  localparam logic [31:0] ADDR = 32'h002081B3;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;

  // control bits: {req, dec, exe, wb, busy, illegal}
  localparam logic [5:0] C_IDLE = 6'b000010;
  localparam logic [5:0] C_REQ  = 6'b100010;
  localparam logic [5:0] C_DEC  = 6'b010010;
  localparam logic [5:0] C_EXE  = 6'b001010;
  localparam logic [5:0] C_WB   = 6'b000110;
  localparam logic [5:0] C_HALT = 6'b000000;
  localparam logic [5:0] C_TRAP = 6'b000001;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        hlt;
    logic [5:0]  exp_ctl;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic [31:0] exp_inst;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] fetched_inst;
  logic        decode_en;
  logic        exec_en;
  logic        wb_en;
  logic [31:0] pc;
  logic        busy;
  logic        illegal_inst;
  logic [31:0] retired_count;

  logic        b_ack;
  logic [31:0] b_rdata;
  logic        b_halt;
  logic        b_req;
  logic [31:0] b_addr;
  logic [31:0] b_inst;
  logic        b_dec;
  logic        b_exe;
  logic        b_wb;
  logic [31:0] b_pc;
  logic        b_busy;
  logic        b_ill;
  logic [31:0] b_ret;

  int n_cmp;
  int n_fail;
  int wb_cnt;
  int last_wb;
  int onehot_bad;
  int found;
  vec_t vecs[21];

  core_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h00000000)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .halt(halt), .fetched_inst(fetched_inst),
    .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en), .pc(pc),
    .busy(busy), .illegal_inst(illegal_inst), .retired_count(retired_count)
  );

  core_sequencer #(.PC_WIDTH(32), .RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk(clk), .reset_n(reset_n),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_ack),
    .imem_rdata(b_rdata), .halt(b_halt), .fetched_inst(b_inst),
    .decode_en(b_dec), .exec_en(b_exe), .wb_en(b_wb), .pc(b_pc),
    .busy(b_busy), .illegal_inst(b_ill), .retired_count(b_ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic a, logic [31:0] rd, logic h, logic [5:0] c,
                              logic [31:0] p, logic [31:0] r, logic [31:0] i);
    vec_t v;
    v.ack = a; v.rdata = rd; v.hlt = h; v.exp_ctl = c;
    v.exp_pc = p; v.exp_ret = r; v.exp_inst = i;
    return v;
  endfunction

  function automatic logic [31:0] ctl_now();
    return {26'd0, imem_req, decode_en, exec_en, wb_en, busy, illegal_inst};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ctl"}, ctl_now(), {26'd0, C_IDLE});
    check({tag, " pc"}, pc, 32'h0);
    check({tag, " retired"}, retired_count, 32'h0);
    check({tag, " inst"}, fetched_inst, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; halt = 1'b0;
    b_ack = 1'b0; b_rdata = 32'h0; b_halt = 1'b0;

    vecs[0]  = mk(1'b1, JUNK, 1'b0, C_IDLE, 32'd0, 32'd0, 32'h0);  // ack without req ignored
    vecs[1]  = mk(1'b1, ADDI, 1'b0, C_REQ,  32'd0, 32'd0, 32'h0);
    vecs[2]  = mk(1'b1, JUNK, 1'b1, C_DEC,  32'd0, 32'd0, ADDI);   // halt in DECODE ignored
    vecs[3]  = mk(1'b0, JUNK, 1'b1, C_EXE,  32'd0, 32'd0, ADDI);
    vecs[4]  = mk(1'b0, JUNK, 1'b0, C_WB,   32'd0, 32'd0, ADDI);
    vecs[5]  = mk(1'b0, JUNK, 1'b1, C_REQ,  32'd4, 32'd1, ADDI);   // wait states begin
    vecs[6]  = mk(1'b0, JUNK, 1'b0, C_REQ,  32'd4, 32'd1, ADDI);
    vecs[7]  = mk(1'b0, JUNK, 1'b0, C_REQ,  32'd4, 32'd1, ADDI);
    vecs[8]  = mk(1'b1, SLTI, 1'b1, C_REQ,  32'd4, 32'd1, ADDI);   // ack wins over halt
    vecs[9]  = mk(1'b0, JUNK, 1'b0, C_DEC,  32'd4, 32'd1, SLTI);
    vecs[10] = mk(1'b0, JUNK, 1'b0, C_EXE,  32'd4, 32'd1, SLTI);
    vecs[11] = mk(1'b0, JUNK, 1'b1, C_WB,   32'd4, 32'd1, SLTI);   // halt in WB
    vecs[12] = mk(1'b0, JUNK, 1'b1, C_HALT, 32'd8, 32'd2, SLTI);
    vecs[13] = mk(1'b0, JUNK, 1'b1, C_HALT, 32'd8, 32'd2, SLTI);
    vecs[14] = mk(1'b0, JUNK, 1'b1, C_HALT, 32'd8, 32'd2, SLTI);
    vecs[15] = mk(1'b0, JUNK, 1'b1, C_HALT, 32'd8, 32'd2, SLTI);
    vecs[16] = mk(1'b0, JUNK, 1'b0, C_HALT, 32'd8, 32'd2, SLTI);
    vecs[17] = mk(1'b1, SLLI, 1'b0, C_REQ,  32'd8, 32'd2, SLTI);   // shift -> trap
    vecs[18] = mk(1'b1, ADDI, 1'b0, C_TRAP, 32'd8, 32'd2, SLLI);
    vecs[19] = mk(1'b1, ADDI, 1'b1, C_TRAP, 32'd8, 32'd2, SLLI);
    vecs[20] = mk(1'b0, JUNK, 1'b0, C_TRAP, 32'd8, 32'd2, SLLI);

    repeat (2) @(posedge clk);
    #1;
    check_reset("in-reset");
    reset_n = 1'b1;

    // Table-driven run: expected outputs at the start of each cycle.
    for (int i = 0; i < 21; i++) begin
      imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata; halt = vecs[i].hlt;
      check($sformatf("vec%0d ctl", i), ctl_now(), {26'd0, vecs[i].exp_ctl});
      check($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d retired", i), retired_count, vecs[i].exp_ret);
      check($sformatf("vec%0d inst", i), fetched_inst, vecs[i].exp_inst);
      if (vecs[i].exp_ctl[5]) check($sformatf("vec%0d addr", i), imem_addr, vecs[i].exp_pc);
      tick();
    end

    // Asynchronous reset out of TRAP, between clock edges.
    #2 reset_n = 1'b0;
    #1 check_reset("trap-reset");
    imem_ack = 1'b0; halt = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait stream of ADDI: period 4, enables one-hot.
    wb_cnt = 0; last_wb = -1; onehot_bad = 0;
    for (int c = 0; c < 80 && wb_cnt < 10; c++) begin
      imem_ack = imem_req; imem_rdata = ADDI;
      if (int'(decode_en) + int'(exec_en) + int'(wb_en) + int'(imem_req) > 1) onehot_bad++;
      if (wb_en) begin
        if (last_wb >= 0) check("wb period", 32'(c - last_wb), 32'd4);
        last_wb = c;
        wb_cnt++;
      end
      tick();
    end
    check("stream wb count", 32'(wb_cnt), 32'd10);
    check("stream onehot", 32'(onehot_bad), 32'd0);
    check("stream pc", pc, 32'd40);
    check("stream retired", retired_count, 32'd10);

    // Run into EXECUTE of the next instruction and reset asynchronously.
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      imem_ack = imem_req; imem_rdata = ADDI;
      if (exec_en) found = 1;
      else tick();
    end
    check("reached execute", 32'(found), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset("exec-reset");
    imem_ack = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    check("post-reset req", {31'd0, imem_req}, 32'd1);
    check("post-reset addr", imem_addr, 32'd0);
    check("post-reset retired", retired_count, 32'd0);

    // R-type opcode traps as well.
    imem_ack = 1'b1; imem_rdata = ADDR;
    tick();
    imem_ack = 1'b0;
    check("rtype ctl", ctl_now(), {26'd0, C_TRAP});
    check("rtype pc", pc, 32'd0);
    check("rtype inst", fetched_inst, ADDR);
    imem_ack = 1'b1; imem_rdata = ADDI;
    repeat (3) tick();
    check("rtype stays trapped", ctl_now(), {26'd0, C_TRAP});

    // PC wrap on the instance reset to the last word of the address space.
    check("wrap first addr", b_addr, 32'hFFFFFFFC);
    check("wrap first req", {31'd0, b_req}, 32'd1);
    b_ack = 1'b1; b_rdata = ADDI;
    tick();
    b_ack = 1'b0;
    check("wrap decode", {31'd0, b_dec}, 32'd1);
    repeat (2) tick();
    check("wrap wb", {31'd0, b_wb}, 32'd1);
    tick();
    check("wrap pc", b_pc, 32'd0);
    check("wrap retired", b_ret, 32'd1);
    check("wrap next req", {31'd0, b_req}, 32'd1);
    check("wrap next addr", b_addr, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
